// File: rtl/pattern_stamper.sv
// Stamps a PATTERN_SIZE x PATTERN_SIZE cell pattern into packed board memory with per-word
// read-modify-write, touching memory only while mem_free_in is high. Optional macro: STAMPER_CLIP_EN.
module pattern_stamper #(
  parameter int WORD_SIZE    = 16,
  parameter int BOARD_SIZE   = 256,
  parameter int LOG_MAX_ADDR = $clog2(BOARD_SIZE*BOARD_SIZE/WORD_SIZE),
  parameter int PATTERN_SIZE = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                                   clk_65mhz,
  input  logic                                   rst_in,
  input  logic                                   start_in,
  input  logic [$clog2(BOARD_SIZE)-1:0]          x_in,
  input  logic [$clog2(BOARD_SIZE)-1:0]          y_in,
  input  logic [PATTERN_SIZE*PATTERN_SIZE-1:0]   pattern_in,
  input  logic [1:0]                             mode_in,
  input  logic                                   mem_free_in,
  input  logic [WORD_SIZE-1:0]                   data_r_in,
  output logic [LOG_MAX_ADDR-1:0]                addr_out,
  output logic                                   wr_en_out,
  output logic [WORD_SIZE-1:0]                   data_w_out,
  output logic                                   busy_out,
  output logic                                   done_out
);
  localparam int CW   = $clog2(BOARD_SIZE);
  localparam int LW   = $clog2(WORD_SIZE);
  localparam int WPR  = BOARD_SIZE / WORD_SIZE;
  localparam int WI   = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int P    = PATTERN_SIZE;
  localparam int PP   = P * P;
  localparam int RW   = (P > 1) ? $clog2(P) : 1;
  localparam int CNTW = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_FINISH} state_t;

  state_t                  r_state;
  logic [PP-1:0]           r_pat;
  logic [1:0]              r_mode;
  logic [LW-1:0]           r_off;
  logic [WI-1:0]           r_w0;
  logic [CW-1:0]           r_row;
  logic [RW-1:0]           r_rcnt;
  logic                    r_second;
  logic [CNTW-1:0]         r_cnt;
  logic [LOG_MAX_ADDR-1:0] r_addr;
  logic                    r_wr_en;
  logic [WORD_SIZE-1:0]    r_data_w;
  logic                    r_busy;
  logic                    r_done;

  logic [P-1:0]             w_row_bits;
  logic [2*WORD_SIZE-1:0]   w_field;
  logic [WORD_SIZE-1:0]     w_mask;
  logic [WORD_SIZE-1:0]     w_wdata;
  logic [WI-1:0]            w_w1;
  logic [WI-1:0]            w_x_word;
  logic [CW-1:0]            w_next_row;
  logic                     w_straddle;
  logic                     w_has_w1;
  logic                     w_last_row;

  function automatic logic [LOG_MAX_ADDR-1:0] f_addr(input logic [CW-1:0] row, input logic [WI-1:0] word);
    return LOG_MAX_ADDR'(row) * LOG_MAX_ADDR'(WPR) + LOG_MAX_ADDR'(word);
  endfunction

  // The current pattern row always sits in the top P bits; the register shifts up one row per row.
  assign w_row_bits = r_pat[PP-1 -: P];
  assign w_field    = {w_row_bits, {(2*WORD_SIZE-P){1'b0}}} >> r_off;
  assign w_mask     = r_second ? w_field[WORD_SIZE-1:0] : w_field[2*WORD_SIZE-1:WORD_SIZE];
  assign w_straddle = (int'(r_off) + P) > WORD_SIZE;
  assign w_w1       = (r_w0 == WI'(WPR-1)) ? '0 : r_w0 + 1'b1;
  assign w_x_word   = WI'(x_in >> LW);
  assign w_next_row = r_row + 1'b1;

`ifdef STAMPER_CLIP_EN
  // A wrapping second word lies past the right board edge; a wrapping row lies past the bottom.
  assign w_has_w1   = w_straddle && (r_w0 != WI'(WPR-1));
  assign w_last_row = (r_rcnt == RW'(P-1)) || (r_row == CW'(BOARD_SIZE-1));
`else
  assign w_has_w1   = w_straddle;
  assign w_last_row = (r_rcnt == RW'(P-1));
`endif

  always_comb begin
    w_wdata = data_r_in;
    case (r_mode)
      2'b00:   w_wdata = data_r_in | w_mask;
      2'b01:   w_wdata = data_r_in & ~w_mask;
      2'b10:   w_wdata = data_r_in ^ w_mask;
      default: w_wdata = data_r_in;
    endcase
  end

  always_ff @(posedge clk_65mhz) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_pat    <= '0;
      r_mode   <= '0;
      r_off    <= '0;
      r_w0     <= '0;
      r_row    <= '0;
      r_rcnt   <= '0;
      r_second <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wr_en  <= 1'b0;
      r_data_w <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_pat    <= pattern_in;
            r_mode   <= mode_in;
            r_off    <= x_in[LW-1:0];
            r_w0     <= w_x_word;
            r_row    <= y_in;
            r_rcnt   <= '0;
            r_second <= 1'b0;
            r_addr   <= f_addr(y_in, w_x_word);
            r_busy   <= 1'b1;
            r_state  <= S_READ;
          end
        end
        // Slot cycle 0 only counts on a cycle where the port is ours; otherwise the address just holds.
        S_READ: begin
          if (mem_free_in) begin
            r_cnt   <= CNTW'(1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_free_in) begin
            r_state <= S_READ;
          end else if (r_cnt == CNTW'(READ_LATENCY)) begin
            r_data_w <= w_wdata;
            r_wr_en  <= (r_mode != 2'b11);
            r_state  <= S_WRITE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          if (!mem_free_in) begin
            r_state <= S_READ;
          end else if (!r_second && w_has_w1) begin
            r_second <= 1'b1;
            r_addr   <= f_addr(r_row, w_w1);
            r_state  <= S_READ;
          end else if (w_last_row) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_second <= 1'b0;
            r_rcnt   <= r_rcnt + 1'b1;
            r_row    <= w_next_row;
            r_pat    <= r_pat << P;
            r_addr   <= f_addr(w_next_row, r_w0);
            r_state  <= S_READ;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // The write strobe is also gated by the live port-ownership and reset inputs so no write escapes either.
  assign addr_out   = r_addr;
  assign wr_en_out  = r_wr_en & mem_free_in & ~rst_in;
  assign data_w_out = r_data_w;
  assign busy_out   = r_busy;
  assign done_out   = r_done;
endmodule

// File: tb/tb_pattern_stamper.sv
// Bench for pattern_stamper: behavioural 2-cycle RAM, directed vector table, hand sequences and
// randomized ops checked against a cell-level board model. Honours STAMPER_CLIP_EN when defined.
module tb_pattern_stamper;
  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic [5:0]  x_in = '0;
  logic [5:0]  y_in = '0;
  logic [63:0] pattern_in = '0;
  logic [1:0]  mode_in = '0;
  logic        mem_free_in = 1'b1;
  logic [15:0] data_r_in;
  logic [7:0]  addr_out;
  logic        wr_en_out;
  logic [15:0] data_w_out;
  logic        busy_out;
  logic        done_out;

  pattern_stamper #(
    .WORD_SIZE(16), .BOARD_SIZE(64), .LOG_MAX_ADDR(8), .PATTERN_SIZE(8), .READ_LATENCY(2)
  ) dut (
    .clk_65mhz(clk), .rst_in(rst_in), .start_in(start_in), .x_in(x_in), .y_in(y_in),
    .pattern_in(pattern_in), .mode_in(mode_in), .mem_free_in(mem_free_in), .data_r_in(data_r_in),
    .addr_out(addr_out), .wr_en_out(wr_en_out), .data_w_out(data_w_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: address seen at edge t, data visible two cycles after it was presented.
  logic [15:0] ram [256];
  logic [15:0] rd_p1, rd_p2;
  logic        seed_all = 1'b0, seed_one = 1'b0;
  logic [7:0]  seed_addr = '0;
  logic [15:0] seed_val = '0;
  always @(posedge clk) begin
    if (seed_all) begin
      for (int i = 0; i < 256; i++) ram[i] <= seed_val;
    end else if (seed_one) begin
      ram[seed_addr] <= seed_val;
    end else if (wr_en_out) begin
      ram[addr_out] <= data_w_out;
    end
    rd_p1 <= ram[addr_out];
    rd_p2 <= rd_p1;
  end
  assign data_r_in = rd_p2;

  logic [15:0] exp_mem [256];
  int total = 0;
  int bad = 0;

  int   wq_addr[$];
  int   wq_data[$];
  int   wq_rel[$];
  bit   done_seen, busy1, busy_done, rst_wr, rst_busy;
  int   done_rel, consec, hold_bad, first_addr, s_cyc;

  typedef struct {
    int          x, y;
    logic [63:0] pat;
    logic [1:0]  mode;
    logic [15:0] fill;
    int          seed_a;
    logic [15:0] seed_v;
    int          n_wr;
    int          a0;
    int          d0;
    int          a1;
    int          d1;
    int          done_at;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic seed(input logic [15:0] fill, input int sa, input logic [15:0] sv);
    @(negedge clk);
    seed_val = fill;
    seed_all = 1'b1;
    @(negedge clk);
    seed_all = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = fill;
    if (sa >= 0) begin
      seed_addr = 8'(sa);
      seed_val  = sv;
      seed_one  = 1'b1;
      @(negedge clk);
      seed_one  = 1'b0;
      exp_mem[sa] = sv;
    end
  endtask

  // Cell-level model: every set pattern bit updates one board cell.
  task automatic stamp(input int x, input int y, input logic [63:0] pat, input logic [1:0] mode, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cx, cy, a, b;
        if (!pat[63 - (r*8 + c)]) continue;
        cx = x + c;
        cy = y + r;
`ifdef STAMPER_CLIP_EN
        if (cx >= 64 || cy >= 64) continue;
`endif
        cx = cx % 64;
        cy = cy % 64;
        a = cy * 4 + cx / 16;
        b = 15 - (cx % 16);
        case (mode)
          2'b00:   exp_mem[a][b] = 1'b1;
          2'b01:   exp_mem[a][b] = 1'b0;
          2'b10:   exp_mem[a][b] = ~exp_mem[a][b];
          default: ;
        endcase
      end
    end
  endtask

  function automatic int exp_slots(input int x, input int y);
    int n = 0;
    for (int r = 0; r < 8; r++) begin
`ifdef STAMPER_CLIP_EN
      if (y + r >= 64) break;
`endif
      n++;
      if ((x % 16) + 8 > 16) begin
`ifdef STAMPER_CLIP_EN
        if (x / 16 != 3) n++;
`else
        n++;
`endif
      end
    end
    return n;
  endfunction

  task automatic ram_chk(input string nm);
    int diffs = 0;
    int first = -1;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== exp_mem[i]) begin
        diffs++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s ram_diffs(first@%0d)", nm, first), diffs, 0);
  endtask

  task automatic run_op(input int x, input int y, input logic [63:0] pat, input logic [1:0] mode,
                        input bit rnd, input int lo_from, input int lo_to, input int rst_at, input int budget);
    bit prev_wr = 1'b0;
    wq_addr.delete(); wq_data.delete(); wq_rel.delete();
    done_seen = 0; busy1 = 0; busy_done = 1; rst_wr = 1; rst_busy = 1;
    done_rel = -1; consec = 0; hold_bad = 0; first_addr = -1;
    @(negedge clk);
    x_in = 6'(x); y_in = 6'(y); pattern_in = pat; mode_in = mode;
    start_in = 1'b1;
    s_cyc = cyc;
    mem_free_in = rnd ? ($urandom_range(3) != 0) : 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start_in = 1'b0;
      if (rnd) mem_free_in = ($urandom_range(3) != 0);
      else     mem_free_in = !(k >= lo_from && k <= lo_to);
      if (k == rst_at) rst_in = 1'b1;
      if (k == rst_at + 1) begin
        rst_in = 1'b0;
        #1;
        rst_wr = wr_en_out;
        rst_busy = busy_out;
        break;
      end
      #1;
      if (k == 1) begin
        busy1 = busy_out;
        first_addr = int'(addr_out);
      end
      if (lo_from >= 0 && k >= lo_from && k <= lo_to + 1 && int'(addr_out) != first_addr) hold_bad++;
      if (wr_en_out) begin
        if (prev_wr) consec++;
        wq_addr.push_back(int'(addr_out));
        wq_data.push_back(int'(data_w_out));
        wq_rel.push_back(k);
      end
      prev_wr = wr_en_out;
      if (done_out) begin
        done_seen = 1;
        done_rel = k;
        busy_done = busy_out;
        break;
      end
    end
    mem_free_in = 1'b1;
    $display("op x=%0d y=%0d pat=%016h mode=%0d writes=%0d done_rel=%0d", x, y, pat, mode, wq_addr.size(), done_rel);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0,  0,  64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 16'h0000, -1, 16'h0, 8, 0, 'hFF00, 4, 'hFF00, 33};
    vecs[1] = '{12, 5,  64'hFF00_0000_0000_0000, 2'b10, 16'h0000, 20, 16'h000F, 16, 20, 'h0000, 21, 'hF000, 65};
`ifdef STAMPER_CLIP_EN
    vecs[2] = '{60, 63, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 16'h0000, -1, 16'h0, 1, 255, 'h000F, 0, 0, 5};
`else
    vecs[2] = '{60, 63, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 16'h0000, -1, 16'h0, 16, 255, 'h000F, 252, 'hF000, 65};
`endif
    vecs[3] = '{3,  10, 64'hA5A5_A5A5_A5A5_A5A5, 2'b11, 16'h1234, -1, 16'h0, 0, 0, 0, 0, 0, 33};
    vecs[4] = '{8,  2,  64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 16'hFFFF, -1, 16'h0, 8, 8, 'hFF00, 12, 'hFF00, 33};
    vecs[5] = '{9,  0,  64'h8100_0000_0000_0000, 2'b00, 16'h0000, -1, 16'h0, 16, 0, 'h0040, 1, 'h8000, 65};

    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    #1;
    chk("reset addr_out", addr_out, 0);
    chk("reset wr_en_out", wr_en_out, 0);
    chk("reset data_w_out", data_w_out, 0);
    chk("reset busy_out", busy_out, 0);
    chk("reset done_out", done_out, 0);

    for (int i = 0; i < 6; i++) begin
      seed(vecs[i].fill, vecs[i].seed_a, vecs[i].seed_v);
      run_op(vecs[i].x, vecs[i].y, vecs[i].pat, vecs[i].mode, 1'b0, -1, -1, -1, 500);
      stamp(vecs[i].x, vecs[i].y, vecs[i].pat, vecs[i].mode, 8);
      chk($sformatf("vec%0d nwrites", i), wq_addr.size(), vecs[i].n_wr);
      if (vecs[i].n_wr >= 1 && wq_addr.size() >= 1) begin
        chk($sformatf("vec%0d addr0", i), wq_addr[0], vecs[i].a0);
        chk($sformatf("vec%0d data0", i), wq_data[0], vecs[i].d0);
        chk($sformatf("vec%0d wr0_cycle", i), wq_rel[0], 4);
      end
      if (vecs[i].n_wr >= 2 && wq_addr.size() >= 2) begin
        chk($sformatf("vec%0d addr1", i), wq_addr[1], vecs[i].a1);
        chk($sformatf("vec%0d data1", i), wq_data[1], vecs[i].d1);
      end
      chk($sformatf("vec%0d done_cycle", i), done_rel, vecs[i].done_at);
      chk($sformatf("vec%0d busy_at_1", i), busy1, 1);
      chk($sformatf("vec%0d busy_at_done", i), busy_done, 0);
      chk($sformatf("vec%0d consecutive_wr", i), consec, 0);
      ram_chk($sformatf("vec%0d", i));
    end

    // Contention: port taken away at slot cycle 2 of the first slot for three cycles.
    seed(16'h0000, -1, 16'h0);
    run_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 3, 5, -1, 500);
    stamp(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 8);
    chk("contend nwrites", wq_addr.size(), 8);
    if (wq_addr.size() >= 1) begin
      chk("contend wr0_cycle", wq_rel[0], 9);
      chk("contend addr0", wq_addr[0], 0);
    end
    chk("contend addr_hold", hold_bad, 0);
    chk("contend done_cycle", done_rel, 38);
    ram_chk("contend");

    // Reset mid-operation at cycle 10, then a fresh toggle op on the partially written board.
    seed(16'h0000, -1, 16'h0);
    run_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, -1, -1, 10, 500);
    chk("reset_mid wr_en", rst_wr, 0);
    chk("reset_mid busy", rst_busy, 0);
    chk("reset_mid nwrites", wq_addr.size(), 2);
    stamp(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 2);
    ram_chk("reset_mid");
    run_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, -1, -1, -1, 500);
    stamp(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 8);
    chk("after_reset done_cycle", done_rel, 33);
    ram_chk("after_reset");

    // Randomized ops with a randomly contended port, accumulating on one board.
    seed(16'(($urandom)), -1, 16'h0);
    for (int n = 0; n < 24; n++) begin
      int rx, ry, exp_n;
      logic [63:0] rp;
      logic [1:0]  rm;
      rx = $urandom_range(63);
      ry = $urandom_range(63);
      rp = {32'($urandom), 32'($urandom)};
      rm = 2'($urandom_range(3));
      exp_n = (rm == 2'b11) ? 0 : exp_slots(rx, ry);
      run_op(rx, ry, rp, rm, 1'b1, -1, -1, -1, 3000);
      stamp(rx, ry, rp, rm, 8);
      chk($sformatf("rnd%0d done_seen", n), done_seen, 1);
      chk($sformatf("rnd%0d nwrites", n), wq_addr.size(), exp_n);
      chk($sformatf("rnd%0d consecutive_wr", n), consec, 0);
      ram_chk($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
